// File: rtl/aes128_type_pkg.sv
// Shared types and constants for the AES-128 MixColumns datapath.
//   mode_t    : ENCRYPT (MixColumns) / DECRYPT (InvMixColumns)
//   state_e   : control states of aes128_mix_columns_par
//   FWD_COEF  : first row of the forward MixColumns matrix {2,3,1,1}
//   INV_COEF  : first row of the inverse MixColumns matrix {14,11,13,9}
//   num_mul_legal() : legal lane counts for the parallel multiplier bank
package aes128_type_pkg;

  typedef enum logic {
    ENCRYPT = 1'b0,
    DECRYPT = 1'b1
  } mode_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_MUL,
    ST_DRAIN,
    ST_DONE
  } state_e;

  // Row r of either matrix is this row rotated right by r positions.
  localparam logic [7:0] FWD_COEF [4] = '{8'h02, 8'h03, 8'h01, 8'h01};
  localparam logic [7:0] INV_COEF [4] = '{8'h0e, 8'h0b, 8'h0d, 8'h09};

  function automatic bit num_mul_legal(input int unsigned n);
    return (n == 1) || (n == 2) || (n == 4);
  endfunction

endpackage

// File: rtl/aes128_gmul.sv
// GF(2^8) multiplier over the AES polynomial x^8+x^4+x^3+x+1.
//   clk_i, rst_n_i : clock, asynchronous active-low reset
//   start_i        : capture a_i*b_i this cycle
//   a_i, b_i       : operands
//   p_o, valid_o   : product, valid one cycle after start_i
module aes128_gmul (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       start_i,
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  output logic [7:0] p_o,
  output logic       valid_o
);

  logic [7:0] p_q, p_d;
  logic       valid_q, valid_d;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  always_comb begin
    valid_d = start_i;
    p_d     = start_i ? gf_mul(a_i, b_i) : p_q;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      p_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      p_q     <= p_d;
      valid_q <= valid_d;
    end
  end

  assign p_o     = p_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/aes128_mix_columns_par.sv
// AES-128 MixColumns / InvMixColumns over a full 128-bit state using
// NUM_MUL parallel GF(2^8) multiplier lanes; results stream out one byte
// at a time with a valid/ready handshake in address order 0..15.
//   clk_i, rst_n_i : clock, asynchronous active-low reset
//   data_i         : state (byte n = data_i[8n+:8]), stable while busy_o
//   start_i        : start one pass (honoured in IDLE only)
//   mode_i         : ENCRYPT / DECRYPT, sampled at start
//   data_o, addr_o : result byte and its state index (4*col+row)
//   valid_o/ready_i: output handshake
//   busy_o, done_o : pass in progress / one-cycle end-of-pass pulse
// Build option: define AES128_MIXCOL_INV_EN to support DECRYPT; otherwise
// mode_i is ignored and every pass computes the forward transform.
module aes128_mix_columns_par
  import aes128_type_pkg::*;
#(
  parameter int unsigned NUM_MUL = 1
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic [127:0] data_i,
  input  logic         start_i,
  input  mode_t        mode_i,
  output logic [7:0]   data_o,
  output logic [3:0]   addr_o,
  output logic         valid_o,
  input  logic         ready_i,
  output logic         busy_o,
  output logic         done_o
);

  if (!num_mul_legal(NUM_MUL)) begin : g_bad_num_mul
    $error("NUM_MUL must be 1, 2 or 4");
  end

  localparam logic [1:0] GRP_LAST = 2'(4 / NUM_MUL - 1);
  localparam logic [1:0] DR_LAST  = 2'(NUM_MUL - 1);

  state_e             state_q, state_d;
  logic [1:0]         grp_q, grp_d;
  logic [1:0]         dr_q, dr_d;
  logic [1:0]         k_q, k_d;
  logic [1:0]         col_idx_q, col_idx_d;
  logic [1:0]         col_nxt;
  logic [31:0]        col_q, col_d;
  logic [7:0]         acc_q [NUM_MUL];
  logic [7:0]         acc_d [NUM_MUL];

  logic               issue;
  logic [1:0]         op_idx;
  logic [7:0]         op_byte;
  logic [7:0]         lane_coef [NUM_MUL];
  logic [7:0]         lane_p [NUM_MUL];
  logic [NUM_MUL-1:0] lane_valid;
  logic               all_valid;
  logic [7:0]         drain_byte;
  logic [1:0]         row_out;

`ifdef AES128_MIXCOL_INV_EN
  mode_t mode_q, mode_d;
`else
  logic  mode_unused;
  assign mode_unused = (mode_i == DECRYPT);
`endif

  assign all_valid = &lane_valid;
  assign col_nxt   = col_idx_q + 2'd1;

  // The k=0 product of each group is issued on the cycle that enters MUL
  // (from LOAD or the last DRAIN handshake), so MUL spends exactly one
  // multiplier latency per product. In LOAD the column register is still
  // being written, so operand byte 0 comes straight from data_i.
  always_comb begin
    state_d   = state_q;
    grp_d     = grp_q;
    dr_d      = dr_q;
    k_d       = k_q;
    col_idx_d = col_idx_q;
    col_d     = col_q;
    acc_d     = acc_q;
    issue     = 1'b0;
    op_idx    = '0;
`ifdef AES128_MIXCOL_INV_EN
    mode_d    = mode_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_LOAD;
`ifdef AES128_MIXCOL_INV_EN
          mode_d  = mode_i;
`endif
        end
      end
      ST_LOAD: begin
        col_d   = data_i[31:0];
        state_d = ST_MUL;
        issue   = 1'b1;
      end
      ST_MUL: begin
        if (all_valid) begin
          for (int unsigned l = 0; l < NUM_MUL; l++) begin
            acc_d[l] = (k_q == 2'd0) ? lane_p[l] : (acc_q[l] ^ lane_p[l]);
          end
          k_d = k_q + 2'd1;
          if (k_q == 2'd3) begin
            state_d = ST_DRAIN;
            // Accumulators now hold this group; the column register can be
            // refilled with the next column while they drain.
            if (grp_q == GRP_LAST && col_idx_q != 2'd3) begin
              col_d = data_i[{col_nxt, 5'b00000} +: 32];
            end
          end else begin
            issue  = 1'b1;
            op_idx = k_q + 2'd1;
          end
        end
      end
      ST_DRAIN: begin
        if (ready_i) begin
          if (dr_q == DR_LAST) begin
            dr_d = '0;
            if (col_idx_q == 2'd3 && grp_q == GRP_LAST) begin
              state_d   = ST_DONE;
              grp_d     = '0;
              col_idx_d = '0;
            end else begin
              state_d = ST_MUL;
              issue   = 1'b1;
              if (grp_q == GRP_LAST) begin
                grp_d     = '0;
                col_idx_d = col_nxt;
              end else begin
                grp_d = grp_q + 2'd1;
              end
            end
          end else begin
            dr_d = dr_q + 2'd1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign op_byte = (state_q == ST_LOAD) ? data_i[7:0] : col_q[{op_idx, 3'b000} +: 8];

  // Coefficients follow grp_d so a product issued on the DRAIN->MUL edge
  // already uses the rows of the group about to start.
  always_comb begin
    logic [1:0] row;
    logic [1:0] sel;
    row = '0;
    sel = '0;
    for (int unsigned l = 0; l < NUM_MUL; l++) begin
      row = 2'(32'(grp_d) * NUM_MUL + l);
      sel = op_idx - row;
`ifdef AES128_MIXCOL_INV_EN
      lane_coef[l] = (mode_q == DECRYPT) ? INV_COEF[sel] : FWD_COEF[sel];
`else
      lane_coef[l] = FWD_COEF[sel];
`endif
    end
  end

  for (genvar l = 0; l < NUM_MUL; l++) begin : g_lane
    aes128_gmul u_gmul (
      .clk_i  (clk_i),
      .rst_n_i(rst_n_i),
      .start_i(issue),
      .a_i    (op_byte),
      .b_i    (lane_coef[l]),
      .p_o    (lane_p[l]),
      .valid_o(lane_valid[l])
    );
  end

  always_comb begin
    drain_byte = '0;
    for (int unsigned l = 0; l < NUM_MUL; l++) begin
      if (dr_q == 2'(l)) drain_byte = acc_q[l];
    end
  end

  assign row_out = 2'(32'(grp_q) * NUM_MUL + 32'(dr_q));
  assign valid_o = (state_q == ST_DRAIN);
  assign data_o  = valid_o ? drain_byte : '0;
  assign addr_o  = valid_o ? {col_idx_q, row_out} : '0;
  assign busy_o  = (state_q != ST_IDLE);
  assign done_o  = (state_q == ST_DONE);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= ST_IDLE;
      grp_q     <= '0;
      dr_q      <= '0;
      k_q       <= '0;
      col_idx_q <= '0;
      col_q     <= '0;
      acc_q     <= '{default: '0};
`ifdef AES128_MIXCOL_INV_EN
      mode_q    <= ENCRYPT;
`endif
    end else begin
      state_q   <= state_d;
      grp_q     <= grp_d;
      dr_q      <= dr_d;
      k_q       <= k_d;
      col_idx_q <= col_idx_d;
      col_q     <= col_d;
      acc_q     <= acc_d;
`ifdef AES128_MIXCOL_INV_EN
      mode_q    <= mode_d;
`endif
    end
  end

endmodule

// File: tb/tb_aes128_mix_columns_par.sv
module tb_aes128_mix_columns_par;
  import aes128_type_pkg::*;

  localparam int N_INST = 3;  // instance i uses NUM_MUL = 1 << i
`ifdef AES128_MIXCOL_INV_EN
  localparam bit INV_EN = 1'b1;
`else
  localparam bit INV_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [127:0] data_r = '0;
  mode_t        mode_r = ENCRYPT;
  logic         start_r [N_INST];
  logic         ready_r [N_INST];
  logic [7:0]   data_w  [N_INST];
  logic [3:0]   addr_w  [N_INST];
  logic         valid_w [N_INST];
  logic         busy_w  [N_INST];
  logic         done_w  [N_INST];

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N_INST; g++) begin : g_dut
    aes128_mix_columns_par #(.NUM_MUL(1 << g)) u_dut (
      .clk_i  (clk),
      .rst_n_i(rst_n),
      .data_i (data_r),
      .start_i(start_r[g]),
      .mode_i (mode_r),
      .data_o (data_w[g]),
      .addr_o (addr_w[g]),
      .valid_o(valid_w[g]),
      .ready_i(ready_r[g]),
      .busy_o (busy_w[g]),
      .done_o (done_w[g])
    );
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: carry-less product then polynomial long division by 0x11b.
  function automatic logic [7:0] gf_ref(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] prod;
    prod = '0;
    for (int i = 0; i < 8; i++) if (b[i]) prod = prod ^ (16'(a) << i);
    for (int i = 14; i >= 8; i--) if (prod[i]) prod = prod ^ (16'h011b << (i - 8));
    return prod[7:0];
  endfunction

  function automatic logic [127:0] mix_ref(input logic [127:0] s, input bit inv);
    int         row [4];
    logic [7:0] x;
    logic [127:0] o;
    if (inv) row = '{14, 11, 13, 9};
    else     row = '{2, 3, 1, 1};
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        x = '0;
        for (int k = 0; k < 4; k++)
          x = x ^ gf_ref(8'(row[(k - r + 4) % 4]), s[8*(4*c+k) +: 8]);
        o[8*(4*c+r) +: 8] = x;
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] exp_for(input logic [127:0] s, input mode_t m);
    return mix_ref(s, INV_EN && (m == DECRYPT));
  endfunction

  // Column c set to bytes written left-to-right (first = row 0), rest zero.
  function automatic logic [127:0] col_at(input int c, input logic [31:0] b);
    logic [127:0] o;
    o = '0;
    for (int k = 0; k < 4; k++) o[8*(4*c+k) +: 8] = b[8*(3-k) +: 8];
    return o;
  endfunction

  task automatic run_pass(input int inst, input logic [127:0] din, input mode_t m,
                          input logic [127:0] exp, input bit stall, input bit chk_len);
    int         cyc, nbytes, ndone, extra, exp_len;
    bit         prev_stall, rdy;
    logic [7:0] prev_d;
    logic [3:0] prev_a;
    exp_len = 2 + 64 / (1 << inst) + 16 + 1;
    @(negedge clk);
    check_eq("busy_idle", 32'(busy_w[inst]), 0);
    data_r = din;
    mode_r = m;
    start_r[inst] = 1'b1;
    ready_r[inst] = 1'b1;
    cyc = 1; nbytes = 0; ndone = 0; prev_stall = 1'b0;
    prev_d = '0; prev_a = '0;
    while (ndone == 0 && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      start_r[inst] = 1'b0;
      if (cyc == 2) check_eq("busy_load", 32'(busy_w[inst]), 1);
      if (prev_stall)
        check_eq("stall_hold", {valid_w[inst], addr_w[inst], data_w[inst]}, {1'b1, prev_a, prev_d});
      if (done_w[inst]) begin
        ndone++;
        if (chk_len) check_eq("pass_len", cyc, exp_len);
      end
      rdy = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      ready_r[inst] = rdy;
      if (valid_w[inst] && rdy) begin
        if (nbytes < 16) begin
          check_eq("addr", 32'(addr_w[inst]), nbytes);
          check_eq("data", 32'(data_w[inst]), 32'(exp[8*nbytes +: 8]));
        end else begin
          check_eq("byte_overrun", nbytes, 15);
        end
        nbytes++;
      end
      prev_stall = valid_w[inst] && !rdy;
      prev_a = addr_w[inst];
      prev_d = data_w[inst];
    end
    check_eq("byte_count", nbytes, 16);
    check_eq("done_seen", ndone, 1);
    ready_r[inst] = 1'b1;
    extra = 0;
    repeat (4) begin
      @(negedge clk);
      if (done_w[inst] || valid_w[inst] || busy_w[inst]) extra++;
    end
    check_eq("post_quiet", extra, 0);
  endtask

  task automatic abort_test();
    logic [127:0] din;
    int cyc, nbytes, quiet;
    din = col_at(1, 32'hdb135345);
    @(negedge clk);
    data_r = din; mode_r = ENCRYPT;
    start_r[0] = 1'b1; ready_r[0] = 1'b1;
    cyc = 0; nbytes = 0;
    while (nbytes < 6 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      start_r[0] = 1'b0;
      if (valid_w[0]) nbytes++;
    end
    @(negedge clk);
    ready_r[0] = 1'b0;
    cyc = 0;
    while (!valid_w[0] && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("pre_abort", {valid_w[0], addr_w[0], data_w[0]}, {1'b1, 4'd6, 8'ha1});
    #2 rst_n = 1'b0;
    #1;
    check_eq("abort_outputs",
             {valid_w[0], addr_w[0], data_w[0], busy_w[0], done_w[0]}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    ready_r[0] = 1'b1;
    quiet = 0;
    repeat (100) begin
      @(negedge clk);
      if (done_w[0] || busy_w[0] || valid_w[0]) quiet++;
    end
    check_eq("abort_no_done", quiet, 0);
    run_pass(0, din, ENCRYPT, mix_ref(din, 1'b0), 1'b0, 1'b1);
  endtask

  initial begin
    logic [127:0] din;
    mode_t m;
    bit st;
    for (int i = 0; i < N_INST; i++) begin
      start_r[i] = 1'b0;
      ready_r[i] = 1'b1;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < N_INST; i++)
      check_eq("reset_outputs", {valid_w[i], addr_w[i], data_w[i], busy_w[i], done_w[i]}, '0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_pass(0, col_at(0, 32'hdb135345), ENCRYPT, col_at(0, 32'h8e4da1bc), 1'b0, 1'b1);
    run_pass(2, col_at(3, 32'hf20a225c), ENCRYPT, col_at(3, 32'h9fdc589d), 1'b0, 1'b1);
    run_pass(0, col_at(2, 32'h8e4da1bc), DECRYPT,
             INV_EN ? col_at(2, 32'hdb135345) : mix_ref(col_at(2, 32'h8e4da1bc), 1'b0),
             1'b0, 1'b1);
    run_pass(1, col_at(0, 32'hdb135345), DECRYPT,
             INV_EN ? mix_ref(col_at(0, 32'hdb135345), 1'b1) : col_at(0, 32'h8e4da1bc),
             1'b0, 1'b1);
    run_pass(1, col_at(0, 32'hdb135345), ENCRYPT, col_at(0, 32'h8e4da1bc), 1'b1, 1'b0);

    abort_test();

    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < N_INST; i++) begin
        din = {$urandom, $urandom, $urandom, $urandom};
        m   = mode_t'($urandom_range(0, 1));
        st  = (t % 2) == 1;
        run_pass(i, din, m, exp_for(din, m), st, !st);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/aes128_mix_columns_par.md
AES128_MIX_COLUMNS_PAR -- requirements
Module: aes128_mix_columns_par

Interface
REQ-001 NUM_MUL, 1, number of parallel GF(2^8) multiplier lanes; legal values 1, 2, 4; any other value fails elaboration.
REQ-002 clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n_i  input  1  reset, asynchronous, active-low.
REQ-004 data_i  input  128  AES state; byte n = data_i[8n+:8], column c = bytes 4c..4c+3, row r = n mod 4; held stable by the source while busy_o=1.
REQ-005 start_i  input  1  single-cycle request to start one full MixColumns/InvMixColumns pass.
REQ-006 mode_i  input  mode_t  ENCRYPT or DECRYPT; sampled at start, held internally for the pass.
REQ-007 data_o  output  8  result byte.
REQ-008 addr_o  output  4  state index of data_o (4*col+row).
REQ-009 valid_o  output  1  data_o/addr_o valid.
REQ-010 ready_i  input  1  sink accepts byte when valid_o&ready_i.
REQ-011 busy_o  output  1  high from the cycle after accepted start until done_o.
REQ-012 done_o  output  1  one-cycle pulse after last byte accepted.

Function
REQ-013 States IDLE, LOAD, MUL, DRAIN, DONE; IDLE->LOAD on start_i; LOAD->MUL; MUL->DRAIN when the lane group finishes 4 products; DRAIN->MUL when group drained and bytes remain; DRAIN->DONE when byte 15 accepted; DONE->IDLE.
REQ-014 start_i outside IDLE is ignored.
REQ-015 LOAD captures the current 32-bit column into the column register; no full-state copy.
REQ-016 Each lane computes one output byte: XOR of 4 products matrix[(k-r) mod 4]*col[k], k=0..3; ENCRYPT row {2,3,1,1}, DECRYPT row {14,11,13,9}.
REQ-017 Lane group g covers rows g*NUM_MUL..g*NUM_MUL+NUM_MUL-1 of the current column; the next column is loaded when its last group enters DRAIN.
REQ-018 A multiply step advances only when all lanes report valid; the accumulator is overwritten at k=0, XORed otherwise.
REQ-019 DRAIN presents group bytes in ascending row order; each byte stays stable on data_o/addr_o/valid_o until ready_i=1; ready_i=0 stalls indefinitely without loss.
REQ-020 Bytes emitted in order addr 0..15, each exactly once per pass.
REQ-021 With ready_i tied 1, pass length = 2 + 16/NUM_MUL*(4*T_MUL) + 16 + 1 cycles, T_MUL = aes128_gmul start-to-valid latency.
REQ-022 valid_o=0 in every state except DRAIN.
REQ-023 Counters wrap to 0 at DONE; no carry into next pass.

Reset
REQ-024 rst_n_i low forces, asynchronously, state IDLE, counters 0, accumulators 0, column register 0, data_o=0, addr_o=0, valid_o=0, busy_o=0, done_o=0.
REQ-025 Reset mid-pass aborts it; no done_o is issued for the aborted pass; first pass after release behaves as from cold reset.

Configuration
REQ-026 Macro AES128_MIXCOL_INV_EN: defined -> DECRYPT supported per REQ-016; undefined -> inverse coefficient logic absent, mode_i ignored, every pass computes ENCRYPT.

Structure
REQ-027 mode_t, the forward and inverse coefficient constants, and NUM_MUL legality check belong in aes128_type_pkg.
REQ-028 NUM_MUL instances of the existing aes128_gmul sub-module; no other sub-module.

Verification
REQ-029 NUM_MUL=1, ENCRYPT, column 0 = db 13 53 45 (others 0) -> bytes 0..3 = 8e 4d a1 bc, bytes 4..15 = 00, done_o once.
REQ-030 DECRYPT (macro defined), column 2 = 8e 4d a1 bc -> addr 8..11 = db 13 53 45.
REQ-031 NUM_MUL=4, ENCRYPT, column 3 = f2 0a 22 5c -> addr 12..15 = 9f dc 58 9d; cycle count per REQ-021.
REQ-032 ready_i randomly low 50% -> identical byte sequence, no drops or duplicates, outputs stable while stalled.
REQ-033 rst_n_i pulsed low after byte 5 -> outputs 0 immediately, no done_o; fresh start gives correct full result.
REQ-034 Macro undefined, mode_i=DECRYPT, column db 13 53 45 -> 8e 4d a1 bc.
